// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges ALU and load results into an in-order
// FIFO and drains at most one register write per cycle, exporting a RAW mask.
module rf_writeback_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RWIDTH = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [RWIDTH-1:0]            alu_rd,
  input  logic [WIDTH-1:0]             alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [RWIDTH-1:0]            mem_rd,
  input  logic [WIDTH-1:0]             mem_data,
  output logic                         mem_ready,
  input  logic                         rf_hold,
  output logic                         rf_we,
  output logic [RWIDTH-1:0]            rf_rd,
  output logic [WIDTH-1:0]             rf_wdata,
  output logic [(2**RWIDTH)-1:0]       pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH+1);
  localparam int unsigned NREG = 2**RWIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [RWIDTH-1:0] r_rd   [DEPTH];
  logic [WIDTH-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_empty;
  logic              w_we;
  logic              w_space;
  logic              w_acc_mem;
  logic              w_acc_alu;
  logic              w_push;
  logic [RWIDTH-1:0] w_in_rd;
  logic [WIDTH-1:0]  w_in_data;
  logic [NREG-1:0]   w_pend;

  always_comb begin
    w_empty   = (r_count == '0);
    w_we      = !w_empty && !rf_hold;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    w_space   = (r_count != FULL) || w_we;
    w_acc_mem = mem_valid && w_space;
    w_acc_alu = alu_valid && w_space && !mem_valid;
    w_in_rd   = w_acc_mem ? mem_rd   : alu_rd;
    w_in_data = w_acc_mem ? mem_data : alu_data;
    w_push    = (w_acc_mem || w_acc_alu) && (w_in_rd != '0);
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pend[r_rd[i]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign mem_ready = w_space;
  assign alu_ready = w_space && !mem_valid;
  assign rf_we     = w_we;
  assign rf_rd     = w_empty ? '0 : r_rd[r_head];
  assign rf_wdata  = w_empty ? '0 : r_data[r_head];
  assign pending   = w_pend;
  assign count     = r_count;

  // Control state; when full, push and pop hit the same slot and the set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_we) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      case ({w_push, w_we})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_rd[r_tail]   <= w_in_rd;
      r_data[r_tail] <= w_in_data;
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_rf_writeback_queue;

  localparam int WIDTH  = 32;
  localparam int RWIDTH = 5;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   alu_valid, mem_valid, rf_hold;
  logic [RWIDTH-1:0]      alu_rd, mem_rd;
  logic [WIDTH-1:0]       alu_data, mem_data;
  logic                   alu_ready, mem_ready, rf_we;
  logic [RWIDTH-1:0]      rf_rd;
  logic [WIDTH-1:0]       rf_wdata;
  logic [(2**RWIDTH)-1:0] pending;
  logic [CW-1:0]          count;

  always #5 clk = ~clk;

  rf_writeback_queue #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic [RWIDTH-1:0] rd;
    logic [WIDTH-1:0]  data;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic e_alu_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic                   ew, sp;
    logic [RWIDTH-1:0]      erd;
    logic [WIDTH-1:0]       ed;
    logic [(2**RWIDTH)-1:0] ep;
    ent_t                   e;
    @(negedge clk);
    ew  = (q.size() != 0) && !rf_hold;
    erd = (q.size() != 0) ? q[0].rd   : '0;
    ed  = (q.size() != 0) ? q[0].data : '0;
    sp  = (q.size() < DEPTH) || ew;
    ep  = '0;
    foreach (q[i]) ep[q[i].rd] = 1'b1;
    ep[0] = 1'b0;
    chk("rf_we",     rf_we,     ew);
    chk("rf_rd",     rf_rd,     erd);
    chk("rf_wdata",  rf_wdata,  ed);
    chk("pending",   pending,   ep);
    chk("count",     count,     q.size());
    chk("mem_ready", mem_ready, sp);
    chk("alu_ready", alu_ready, sp && !mem_valid);
    @(posedge clk);
    e_alu_acc = 1'b0;
    if (!rst_n) q.delete();
    else begin
      if (ew) void'(q.pop_front());
      if (mem_valid && sp) begin
        e.rd = mem_rd; e.data = mem_data;
        if (mem_rd != 0) q.push_back(e);
      end else if (alu_valid && sp) begin
        e_alu_acc = 1'b1;
        e.rd = alu_rd; e.data = alu_data;
        if (alu_rd != 0) q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic push_alu(input logic [RWIDTH-1:0] rd, input logic [WIDTH-1:0] d,
                          input bit toggle_hold);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    for (int k = 0; k < 20; k++) begin
      if (toggle_hold) rf_hold = ~rf_hold;
      step();
      if (e_alu_acc) break;
    end
    chk("alu_push_accepted", e_alu_acc, 1'b1);
    alu_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rf_hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    @(posedge clk); #1;
    q.delete();
    step();
    chk("rst_count", count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    rst_n = 1'b1;
    step();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    chk("single_we", rf_we, 1);
    chk("single_rd", rf_rd, 5);
    chk("single_data", rf_wdata, 32'hDEADBEEF);
    chk("single_pend5", pending[5], 1);
    step();
    chk("single_we_after", rf_we, 0);
    chk("single_pend_after", pending, 0);
    chk("single_count_after", count, 0);

    // Load beats ALU; ALU holds until accepted
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
    #1;
    chk("prio_mem_ready", mem_ready, 1);
    chk("prio_alu_ready", alu_ready, 0);
    step();
    mem_valid = 1'b0;
    chk("prio_first_rd", rf_rd, 4);
    step();
    idle();
    chk("prio_second_rd", rf_rd, 3);
    chk("prio_second_data", rf_wdata, 32'h1);
    step();

    // Fill under hold, then drain with a same-cycle push at full
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push_alu(5'(i), 32'h10 + 32'(i - 1), 1'b0);
    chk("full_count", count, 4);
    chk("full_pending", pending, 32'h1E);
    chk("full_alu_ready", alu_ready, 0);
    step();
    rf_hold = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    #1;
    chk("full_first_rd", rf_rd, 1);
    chk("full_push_ready", alu_ready, 1);
    step();
    idle();
    chk("full_count_kept", count, 4);
    for (int i = 0; i < 6; i++) step();
    chk("full_drained", count, 0);

    // x0 result is acknowledged but never queued
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'hFFFFFFFF;
    #1;
    chk("x0_ready", alu_ready, 1);
    step();
    idle();
    chk("x0_count", count, 0);
    chk("x0_we", rf_we, 0);
    chk("x0_pend0", pending[0], 0);
    step();

    // Wrap with duplicate destinations and toggling hold
    for (int i = 1; i <= 6; i++) push_alu((i % 2) ? 5'd7 : 5'd8, 32'(i), 1'b1);
    rf_hold = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("wrap_drained", count, 0);

    // Reset mid-operation drops queued work
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) push_alu(5'(10 + i), 32'hA0 + 32'(i), 1'b0);
    chk("midrst_pre_count", count, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rf_hold = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_we", rf_we, 0);
    for (int i = 0; i < 4; i++) step();

    // Random traffic, ALU inputs held stable while blocked
    for (int n = 0; n < 600; n++) begin
      if (!(alu_valid && !e_alu_acc)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 9));
        alu_data  = $urandom;
      end
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rd    = 5'($urandom_range(0, 9));
      mem_data  = $urandom;
      rf_hold   = ($urandom_range(0, 2) == 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      step();
    end
    rst_n = 1'b1; idle(); rf_hold = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
